copper_ctrl: RTL and testbench

Copper sequencer: fetches 32-bit copper instructions (two 16-bit words) from `coppermem` through its synchronous read port, compares them against the video beam position, and issues palette writes, skips, jumps and waits. It sits between the video timing generator, `coppermem`'s read port and the colour palette write port. It is the only requester on the `coppermem` read port. Host writes use `coppermem`'s separate write port and are out of scope.

---
 rtl/copper_ctrl.sv | 154 +++++++++++++++
 tb/tb_copper_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/copper_ctrl.sv
// Copper sequencer: fetches two-word instructions from coppermem, waits on the
// video beam position and issues palette writes, skips, jumps and waits.
module copper_ctrl #(
  parameter int COP_ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  cop_en_i,
  input  logic                  end_of_frame_i,
  input  logic [10:0]           h_count_i,
  input  logic [10:0]           v_count_i,
  output logic                  coppermem_rd_en_o,
  output logic [COP_ADDR_W-1:0] coppermem_rd_addr_o,
  input  logic [15:0]           coppermem_rd_data_i,
  output logic                  pal_wr_en_o,
  output logic [7:0]            pal_wr_addr_o,
  output logic [15:0]           pal_wr_data_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_F0    = 3'd1,
    S_F1    = 3'd2,
    S_EX    = 3'd3,
    S_WAITB = 3'd4,
    S_WAITF = 3'd5
  } state_t;

  localparam logic [3:0] OP_WAIT  = 4'h0;
  localparam logic [3:0] OP_SKIP  = 4'h2;
  localparam logic [3:0] OP_JMP   = 4'h4;
  localparam logic [3:0] OP_MOVEP = 4'hB;

  state_t                state_q;
  logic [COP_ADDR_W-1:0] pc_q;
  logic [COP_ADDR_W-1:0] last_addr_q;
  logic [15:0]           w0_q;
  logic [15:0]           w1_q;
  logic                  pal_wr_en_q;
  logic [7:0]            pal_wr_addr_q;
  logic [15:0]           pal_wr_data_q;

  logic [COP_ADDR_W-1:0] pc_p1, pc_p2, pc_p4;
  logic [COP_ADDR_W-1:0] ex_pc_d;
  state_t                ex_state_d;
  logic                  ex_wr_d;
  logic                  ex_met, wb_met;
  logic                  unused_bits;

  assign pc_p1 = pc_q + COP_ADDR_W'(1);
  assign pc_p2 = pc_q + COP_ADDR_W'(2);
  assign pc_p4 = pc_q + COP_ADDR_W'(4);

  // Unsigned beam compare; flags[0] drops the Y test, flags[1] drops the X test.
  function automatic logic cond_met(input logic [15:0] w0, input logic [15:0] w1,
                                    input logic [10:0] h, input logic [10:0] v);
    return (w1[0] | (v >= w0[10:0])) & (w1[1] | (h >= w1[14:4]));
  endfunction

  assign ex_met = cond_met(w0_q, coppermem_rd_data_i, h_count_i, v_count_i);
  assign wb_met = cond_met(w0_q, w1_q, h_count_i, v_count_i);

  always_comb begin
    ex_pc_d    = pc_p2;
    ex_state_d = S_F0;
    ex_wr_d    = 1'b0;
    case (w0_q[15:12])
      OP_WAIT: begin
        if (coppermem_rd_data_i[1:0] == 2'b11) begin
          ex_pc_d    = pc_q;
          ex_state_d = S_WAITF;
        end else if (!ex_met) begin
          ex_pc_d    = pc_q;
          ex_state_d = S_WAITB;
        end
      end
      OP_SKIP:  ex_pc_d = ex_met ? pc_p4 : pc_p2;
      OP_JMP:   ex_pc_d = w0_q[COP_ADDR_W-1:0];
      OP_MOVEP: ex_wr_d = 1'b1;
      default:  ex_pc_d = pc_p2;
    endcase
  end

  // Read port is driven straight from state/pc; the address parks on its last value.
  always_comb begin
    coppermem_rd_en_o   = 1'b0;
    coppermem_rd_addr_o = last_addr_q;
    if (state_q == S_F0) begin
      coppermem_rd_en_o   = 1'b1;
      coppermem_rd_addr_o = pc_q;
    end else if (state_q == S_F1) begin
      coppermem_rd_en_o   = 1'b1;
      coppermem_rd_addr_o = pc_p1;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      last_addr_q   <= '0;
      w0_q          <= '0;
      w1_q          <= '0;
      pal_wr_en_q   <= 1'b0;
      pal_wr_addr_q <= '0;
      pal_wr_data_q <= '0;
    end else begin
      last_addr_q <= coppermem_rd_addr_o;
      pal_wr_en_q <= 1'b0;
      if (!cop_en_i) begin
        state_q <= S_IDLE;
        pc_q    <= '0;
      end else if (end_of_frame_i) begin
        // Frame restart wins over everything, including a MOVEP in EX.
        state_q <= S_F0;
        pc_q    <= '0;
      end else begin
        case (state_q)
          S_IDLE: state_q <= S_IDLE;
          S_F0:   state_q <= S_F1;
          S_F1: begin
            w0_q    <= coppermem_rd_data_i;
            state_q <= S_EX;
          end
          S_EX: begin
            w1_q    <= coppermem_rd_data_i;
            pc_q    <= ex_pc_d;
            state_q <= ex_state_d;
            if (ex_wr_d) begin
              pal_wr_en_q   <= 1'b1;
              pal_wr_addr_q <= w0_q[7:0];
              pal_wr_data_q <= coppermem_rd_data_i;
            end
          end
          S_WAITB: begin
            if (wb_met) begin
              pc_q    <= pc_p2;
              state_q <= S_F0;
            end
          end
          S_WAITF: state_q <= S_WAITF;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign pal_wr_en_o   = pal_wr_en_q;
  assign pal_wr_addr_o = pal_wr_addr_q;
  assign pal_wr_data_o = pal_wr_data_q;

  assign unused_bits = ^{w0_q[11], w1_q[15], w1_q[3:2]};

endmodule

// File: tb/tb_copper_ctrl.sv
// Bench for copper_ctrl: directed scenarios plus random programs checked against
// an instruction-level model of palette write timing.
module tb_copper_ctrl;
  localparam int AW = 10;
  localparam int W  = 150;

  logic          clk = 1'b0;
  logic          reset_i, cop_en_i, eof;
  logic [10:0]   h, v;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;
  logic          pal_wr_en;
  logic [7:0]    pal_wr_addr;
  logic [15:0]   pal_wr_data;

  logic [15:0] mem [1024];
  bit          exp_en   [W+1];
  logic [7:0]  exp_addr [W+1];
  logic [15:0] exp_data [W+1];
  int wrap_ra [8]  = '{0, 1, -1, 1023, 0, -1, 1, 2};
  int jmp_ra  [10] = '{0, 1, -1, 1022, 1023, -1, 1022, 1023, -1, 1022};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  copper_ctrl #(.COP_ADDR_W(AW)) dut (
    .clk                 (clk),
    .reset_i             (reset_i),
    .cop_en_i            (cop_en_i),
    .end_of_frame_i      (eof),
    .h_count_i           (h),
    .v_count_i           (v),
    .coppermem_rd_en_o   (rd_en),
    .coppermem_rd_addr_o (rd_addr),
    .coppermem_rd_data_i (rd_data),
    .pal_wr_en_o         (pal_wr_en),
    .pal_wr_addr_o       (pal_wr_addr),
    .pal_wr_data_o       (pal_wr_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
  endtask

  task automatic frame();
    eof = 1'b1;
    tick();
    eof = 1'b0;
  endtask

  initial begin
    int pc, s, r, op;
    bit done, met;
    logic [15:0] w0, w1;

    reset_i = 1'b1; cop_en_i = 1'b0; eof = 1'b0; h = '0; v = '0; rd_data = '0;
    clear_mem();
    #12;
    chk("rst_rd_en",   32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_wr_en",   32'(pal_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(pal_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(pal_wr_data), 32'd0);
    reset_i = 1'b0;
    tick();

    // Single MOVEP then NEXTF
    mem[0] = 16'hB000; mem[1] = 16'h0F00; mem[2] = 16'h0000; mem[3] = 16'h0003;
    cop_en_i = 1'b1;
    tick();
    chk("idle_no_eof_rd_en", 32'(rd_en), 32'd0);
    frame();
    for (int k = 1; k <= 14; k++) begin
      chk("t1_wr_en", 32'(pal_wr_en), 32'(k == 4));
      if (k == 1) chk("t1_f0_rd_en", 32'(rd_en), 32'd1);
      if (k == 4) begin
        chk("t1_wr_addr", 32'(pal_wr_addr), 32'h00);
        chk("t1_wr_data", 32'(pal_wr_data), 32'h0F00);
      end
      if (k >= 7) chk("t1_waitf_rd_en", 32'(rd_en), 32'd0);
      tick();
    end
    frame();
    chk("t1_eof_refetch", 32'(rd_en), 32'd1);

    // WAIT on Y=160 with X ignored
    clear_mem();
    mem[0] = 16'h00A0; mem[1] = 16'h0002;
    v = 11'd150; h = 11'd0;
    frame();
    tick(); tick(); tick();
    chk("wait_hold_rd_en", 32'(rd_en), 32'd0);
    for (int vv = 151; vv <= 160; vv++) begin
      v = 11'(vv);
      h = 11'($urandom_range(0, 2047));
      tick();
      if (vv < 160) begin
        chk("wait_hold_rd_en", 32'(rd_en), 32'd0);
        chk("wait_hold_addr",  32'(rd_addr), 32'd1);
      end else begin
        chk("wait_exit_rd_en", 32'(rd_en), 32'd1);
        chk("wait_exit_addr",  32'(rd_addr), 32'd2);
      end
    end

    // Fetch at pc=1023 wraps w1 to address 0
    clear_mem();
    mem[0] = 16'h43FF; mem[1023] = 16'hB055;
    frame();
    for (int k = 1; k <= 8; k++) begin
      if (wrap_ra[k-1] >= 0) chk("wrap_rd_addr", 32'(rd_addr), 32'(wrap_ra[k-1]));
      chk("wrap_no_x", 32'($isunknown({rd_en, rd_addr, pal_wr_en, pal_wr_addr, pal_wr_data})), 32'd0);
      chk("wrap_wr_en", 32'(pal_wr_en), 32'(k == 7));
      if (k == 7) begin
        chk("wrap_wr_addr", 32'(pal_wr_addr), 32'h55);
        chk("wrap_wr_data", 32'(pal_wr_data), 32'h43FF);
      end
      tick();
    end

    // JMP at 1022 to itself
    clear_mem();
    mem[0] = 16'h43FE; mem[1022] = 16'h43FE;
    frame();
    for (int k = 1; k <= 10; k++) begin
      if (jmp_ra[k-1] >= 0) chk("jmp_rd_addr", 32'(rd_addr), 32'(jmp_ra[k-1]));
      tick();
    end
    frame();
    chk("jmp_break_addr", 32'(rd_addr), 32'd0);

    // EOF in the EX cycle of a MOVEP
    clear_mem();
    mem[0] = 16'hB012; mem[1] = 16'h0ABC; mem[2] = 16'h0000; mem[3] = 16'h0003;
    frame();
    tick(); tick();
    frame();
    chk("eofex_wr_en",   32'(pal_wr_en), 32'd0);
    chk("eofex_rd_en",   32'(rd_en), 32'd1);
    chk("eofex_rd_addr", 32'(rd_addr), 32'd0);
    tick(); tick(); tick();
    chk("eofex_next_wr_en",   32'(pal_wr_en), 32'd1);
    chk("eofex_next_wr_addr", 32'(pal_wr_addr), 32'h12);
    chk("eofex_next_wr_data", 32'(pal_wr_data), 32'h0ABC);

    // Disable during WAITB
    clear_mem();
    mem[0] = 16'hB0AA; mem[1] = 16'h0123; mem[2] = 16'h07FF; mem[3] = 16'h0000;
    v = 11'd0; h = 11'd0;
    frame();
    for (int k = 1; k < 8; k++) tick();
    chk("waitb_rd_en", 32'(rd_en), 32'd0);
    cop_en_i = 1'b0;
    tick();
    chk("dis_rd_en", 32'(rd_en), 32'd0);
    chk("dis_wr_en", 32'(pal_wr_en), 32'd0);
    cop_en_i = 1'b1;
    v = 11'd2047;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("reen_idle_rd_en", 32'(rd_en), 32'd0);
    end
    v = 11'd0;
    frame();
    chk("reen_eof_rd_en",   32'(rd_en), 32'd1);
    chk("reen_eof_rd_addr", 32'(rd_addr), 32'd0);

    // Async reset during WAITB
    for (int k = 1; k < 8; k++) tick();
    chk("pre_rst_wr_addr", 32'(pal_wr_addr), 32'hAA);
    #2 reset_i = 1'b1;
    #1;
    chk("arst_rd_en",   32'(rd_en), 32'd0);
    chk("arst_rd_addr", 32'(rd_addr), 32'd0);
    chk("arst_wr_en",   32'(pal_wr_en), 32'd0);
    chk("arst_wr_addr", 32'(pal_wr_addr), 32'd0);
    chk("arst_wr_data", 32'(pal_wr_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    v = 11'd2047;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_idle_rd_en", 32'(rd_en), 32'd0);
    end
    frame();
    chk("post_rst_eof_rd_en", 32'(rd_en), 32'd1);

    // Random programs against an instruction-level timing model
    for (int trial = 0; trial < 25; trial++) begin
      clear_mem();
      for (int a = 0; a < 32; a += 2) begin
        r = int'($urandom_range(0, 9));
        op = (r < 2) ? 0 : (r < 4) ? 2 : (r == 4) ? 4 : (r < 9) ? 11 : 7;
        if (op == 4) mem[a] = {4'h4, 2'b00, 10'($urandom_range(0, 15) * 2)};
        else         mem[a] = {4'(op), 1'b0, 11'($urandom_range(0, 600))};
        mem[a+1] = {1'b0, 11'($urandom_range(0, 800)), 4'($urandom_range(0, 15))};
      end
      h = 11'($urandom_range(0, 799));
      v = 11'($urandom_range(0, 524));

      for (int k = 0; k <= W; k++) begin
        exp_en[k] = 1'b0; exp_addr[k] = '0; exp_data[k] = '0;
      end
      pc = 0; s = 1; done = 1'b0;
      while (!done && s + 3 <= W) begin
        w0  = mem[pc];
        w1  = mem[(pc + 1) % 1024];
        met = (w1[0] || v >= w0[10:0]) && (w1[1] || h >= w1[14:4]);
        case (int'(w0[15:12]))
          0:  if (w1[1:0] == 2'b11 || !met) done = 1'b1; else pc += 2;
          2:  pc += met ? 4 : 2;
          4:  pc = int'(w0[9:0]);
          11: begin
            exp_en[s+3] = 1'b1; exp_addr[s+3] = w0[7:0]; exp_data[s+3] = w1;
            pc += 2;
          end
          default: pc += 2;
        endcase
        pc = pc % 1024;
        s += 3;
      end

      frame();
      for (int k = 1; k <= W; k++) begin
        chk("rnd_wr_en", 32'(pal_wr_en), 32'(exp_en[k]));
        if (exp_en[k]) begin
          chk("rnd_wr_addr", 32'(pal_wr_addr), 32'(exp_addr[k]));
          chk("rnd_wr_data", 32'(pal_wr_data), 32'(exp_data[k]));
        end
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
